b_sram_ctrl: RTL and testbench

Port controller for the B-operand SRAM (`b_sram`, 264-bit words, single address port). It shares the port between a write requester (the loader streaming B vectors in) and the array-side read sequencer. On request it replays one tile of `ACC_DEPTH` consecutive B vectors to the systolic array. All SRAM command outputs are registered, so the SRAM sees clean, reset-safe controls.

---
 rtl/b_sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_b_sram_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_sram_ctrl.sv
// Port controller for the B-operand SRAM: arbitrates loader writes against tile replays to the array.
// Optional feature macro: B_SRAM_HAZARD_CHECK_EN (per-tile written flags, reads wait for a complete tile).
module b_sram_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 264,
  parameter int ACC_DEPTH  = 16,
  parameter int NUM_TILES  = 8,
  localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int IDX_W  = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_start,
  input  logic [TILE_W-1:0]     rd_tile,
  output logic                  rd_busy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  output logic [IDX_W-1:0]      rd_vec_idx,
  output logic                  rd_done,
  output logic                  sram_write_en,
  output logic                  sram_output_en,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data_in,
  input  logic [DATA_WIDTH-1:0] sram_data_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_DEPTH - 1);

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [IDX_W-1:0]      cnt;
  logic                  drain_cnt;
  logic                  start_acc, wr_acc;
  logic                  start_ok, wait_ok;
  logic                  issue_d1, issue_d2;
  logic [IDX_W-1:0]      idx_d1, idx_d2;

  assign start_acc     = rd_start && (state == ST_IDLE);
  assign wr_acc        = wr_valid && wr_ready;
  // Gated by rst_n so the port reports not-ready while held in reset.
  assign wr_ready      = rst_n && (state != ST_READ);
  assign rd_busy       = (state != ST_IDLE);
  assign rd_data       = sram_data_out;
  assign rd_data_valid = issue_d2;
  assign rd_vec_idx    = idx_d2;
  assign rd_done       = issue_d2 && (idx_d2 == LAST_IDX);

`ifdef B_SRAM_HAZARD_CHECK_EN
  logic [NUM_TILES-1:0] tile_written;
  logic [TILE_W-1:0]    cur_tile;

  assign start_ok = tile_written[rd_tile];
  assign wait_ok  = tile_written[cur_tile];

  // Clear is applied before set so a coincident write of the last vector wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_written <= '0;
      cur_tile     <= '0;
    end else begin
      if (start_acc) cur_tile <= rd_tile;
      for (int unsigned t = 0; t < NUM_TILES; t++) begin
        if (rd_done && (cur_tile == TILE_W'(t)))
          tile_written[t] <= 1'b0;
        if (wr_acc && (wr_addr == ADDR_WIDTH'(t * ACC_DEPTH + ACC_DEPTH - 1)))
          tile_written[t] <= 1'b1;
      end
    end
  end
`else
  assign start_ok = 1'b1;
  assign wait_ok  = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (rd_start) state_nxt = start_ok ? ST_READ : ST_WAIT;
      ST_WAIT:  if (wait_ok) state_nxt = ST_READ;
      ST_READ:  if (cnt == LAST_IDX) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      base      <= '0;
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_acc) begin
        base <= ADDR_WIDTH'(rd_tile) * ADDR_WIDTH'(ACC_DEPTH);
        cnt  <= '0;
      end else if (state == ST_READ) begin
        cnt <= cnt + 1'b1;
      end
      drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Registered SRAM command; READ owns the port, otherwise an accepted write issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_write_en  <= 1'b0;
      sram_output_en <= 1'b0;
      sram_addr      <= '0;
      sram_data_in   <= '0;
    end else if (state == ST_READ) begin
      sram_write_en  <= 1'b0;
      sram_output_en <= 1'b1;
      sram_addr      <= base + ADDR_WIDTH'(cnt);
    end else if (wr_acc) begin
      sram_write_en  <= 1'b1;
      sram_output_en <= 1'b0;
      sram_addr      <= wr_addr;
      sram_data_in   <= wr_data;
    end else begin
      sram_write_en  <= 1'b0;
      sram_output_en <= 1'b0;
    end
  end

  // Two stages: command register, then the SRAM output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_d1 <= 1'b0;
      issue_d2 <= 1'b0;
      idx_d1   <= '0;
      idx_d2   <= '0;
    end else begin
      issue_d1 <= (state == ST_READ);
      idx_d1   <= cnt;
      issue_d2 <= issue_d1;
      idx_d2   <= idx_d1;
    end
  end

endmodule

// File: tb/tb_b_sram_ctrl.sv
// Directed bench for b_sram_ctrl with a behavioural registered-output SRAM and a reference memory image.
module tb_b_sram_ctrl;

  localparam int AW = 11;
  localparam int DW = 264;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_start;
  logic [2:0]    rd_tile;
  logic          rd_busy;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic [3:0]    rd_vec_idx;
  logic          rd_done;
  logic          sram_write_en;
  logic          sram_output_en;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data_in;
  logic [DW-1:0] sram_data_out;

  b_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACC_DEPTH(16), .NUM_TILES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_start(rd_start), .rd_tile(rd_tile), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_vec_idx(rd_vec_idx), .rd_done(rd_done),
    .sram_write_en(sram_write_en), .sram_output_en(sram_output_en),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] exp_mem [0:2047];
  logic [DW-1:0] sram_q = '0;
  assign sram_data_out = sram_q;

  always @(posedge clk) begin
    if (sram_write_en)  mem[sram_addr] <= sram_data_in;
    if (sram_output_en) sram_q <= mem[sram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr1(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
    chk("wr_ready outside read", wr_ready, 1);
    exp_mem[a] = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic arm(input int tile);
`ifdef B_SRAM_HAZARD_CHECK_EN
    wr1(tile * 16 + 15, exp_mem[tile * 16 + 15]);
`else
    if (tile < 0) $display("negative tile %0d", tile);
`endif
  endtask

  // mode 0: no writes; 1: single write (wa0, wd0) with rd_start; 2: wr_valid held, addresses from wa0
  task automatic read_tile(input int tile, input int mode, input int wa0, input logic [DW-1:0] wd0,
                           input int repulse_c);
    int wa;
    int base;
    logic e_busy, e_rdy, e_val, e_oe;
    logic [DW-1:0] d;
    wa = wa0;
    base = tile * 16;
    @(negedge clk);
    for (int c = 0; c <= 20; c++) begin
      rd_start = (c == 0) || (c == repulse_c);
      rd_tile  = (c == 0) ? 3'(tile) : 3'd7;
      wr_valid = (mode == 2) || (mode == 1 && c == 0);
      d = '0;
      d[AW-1:0] = AW'(wa);
      d[DW-1:DW-8] = 8'hA5;
      wr_addr = AW'(wa);
      wr_data = (mode == 1) ? wd0 : d;
      e_busy = (c >= 1 && c <= 18);
      e_rdy  = !(c >= 1 && c <= 16);
      e_val  = (c >= 3 && c <= 18);
      e_oe   = (c >= 2 && c <= 17);
      chk($sformatf("t%0d rd_busy c%0d", tile, c), rd_busy, e_busy);
      chk($sformatf("t%0d wr_ready c%0d", tile, c), wr_ready, e_rdy);
      chk($sformatf("t%0d rd_data_valid c%0d", tile, c), rd_data_valid, e_val);
      chk($sformatf("t%0d rd_done c%0d", tile, c), rd_done, (c == 18));
      chk($sformatf("t%0d output_en c%0d", tile, c), sram_output_en, e_oe);
      chk($sformatf("t%0d we&oe c%0d", tile, c), sram_write_en & sram_output_en, 0);
      if (e_oe) chk($sformatf("t%0d sram_addr c%0d", tile, c), sram_addr, DW'(base + c - 2));
      if (e_val) begin
        chk($sformatf("t%0d rd_vec_idx c%0d", tile, c), rd_vec_idx, DW'(c - 3));
        chk($sformatf("t%0d rd_data c%0d", tile, c), rd_data, exp_mem[base + c - 3]);
      end
      if (wr_valid && e_rdy) begin
        exp_mem[wa] = wr_data;
        if (mode == 2) wa++;
      end
      @(negedge clk);
    end
    rd_start = 1'b0;
    wr_valid = 1'b0;
  endtask

  typedef struct {
    logic          wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_we;
    logic          e_oe;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] big;
    int k;
    big = '0;
    big[DW-1:DW-8] = 8'h5A;
    big[15:0] = 16'h0123;
    vecs[0] = '{1'b1, 11'd5,   264'hAA, 1'b1, 1'b0, 11'd5,   264'hAA};
    vecs[1] = '{1'b0, 11'd7,   264'hBB, 1'b0, 1'b0, 11'd5,   264'hAA};
    vecs[2] = '{1'b1, 11'h7FF, big,     1'b1, 1'b0, 11'h7FF, big};
    vecs[3] = '{1'b0, 11'd9,   264'hCC, 1'b0, 1'b0, 11'h7FF, big};

    for (int i = 0; i < 2048; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    rst_n = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_start = 1'b0; rd_tile = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset wr_ready", wr_ready, 0);
    chk("reset rd_busy", rd_busy, 0);
    chk("reset rd_data_valid", rd_data_valid, 0);
    chk("reset rd_done", rd_done, 0);
    chk("reset rd_vec_idx", rd_vec_idx, 0);
    chk("reset write_en", sram_write_en, 0);
    chk("reset output_en", sram_output_en, 0);
    chk("reset sram_addr", sram_addr, 0);
    chk("reset sram_data_in", sram_data_in, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset wr_ready", wr_ready, 1);
    chk("post-reset rd_busy", rd_busy, 0);

    // Command register behaviour while idle: write issue and hold of addr/data.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      chk($sformatf("vec%0d wr_ready", i), wr_ready, 1);
      if (vecs[i].wv) exp_mem[vecs[i].wa] = vecs[i].wd;
      @(negedge clk);
      wr_valid = 1'b0;
      chk($sformatf("vec%0d write_en", i), sram_write_en, vecs[i].e_we);
      chk($sformatf("vec%0d output_en", i), sram_output_en, vecs[i].e_oe);
      chk($sformatf("vec%0d sram_addr", i), sram_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d sram_data_in", i), sram_data_in, vecs[i].e_din);
    end

    for (int a = 0; a < 64; a++) wr1(a, DW'(a));

    arm(0);
    read_tile(0, 0, 0, '0, -1);
    arm(0);
    read_tile(0, 2, 100, '0, 5);
    arm(6);
    read_tile(6, 0, 0, '0, -1);
    arm(1);
    read_tile(1, 1, 16, 264'hDEAD_BEEF_0016, -1);

    // Reset in the middle of a tile.
    arm(0);
    @(negedge clk); rd_start = 1'b1; rd_tile = 3'd0;
    @(negedge clk); rd_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre-reset beat valid", rd_data_valid, 1);
    chk("pre-reset beat idx", rd_vec_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("midreset wr_ready", wr_ready, 0);
    chk("midreset rd_busy", rd_busy, 0);
    chk("midreset rd_data_valid", rd_data_valid, 0);
    chk("midreset rd_done", rd_done, 0);
    chk("midreset rd_vec_idx", rd_vec_idx, 0);
    chk("midreset output_en", sram_output_en, 0);
    chk("midreset write_en", sram_write_en, 0);
    chk("midreset sram_addr", sram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("after reset rd_done c%0d", c), rd_done, 0);
      chk($sformatf("after reset rd_busy c%0d", c), rd_busy, 0);
    end
    chk("after reset wr_ready", wr_ready, 1);
    arm(3);
    read_tile(3, 0, 0, '0, -1);

`ifdef B_SRAM_HAZARD_CHECK_EN
    // Tile 2 flags were cleared by reset, so the read parks in WAIT.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); rd_start = 1'b1; rd_tile = 3'd2;
      @(negedge clk); rd_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("wait%0d busy c%0d", pass, c), rd_busy, 1);
        chk($sformatf("wait%0d output_en c%0d", pass, c), sram_output_en, 0);
        chk($sformatf("wait%0d wr_ready c%0d", pass, c), wr_ready, 1);
        @(negedge clk);
      end
      wr_valid = 1'b1; wr_addr = 11'd47; wr_data = DW'(1000 + pass);
      exp_mem[47] = wr_data;
      @(negedge clk); wr_valid = 1'b0;
      k = 0;
      while (!rd_data_valid && k < 10) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("wait%0d release latency", pass), DW'(k), 3);
      chk($sformatf("wait%0d beat0 idx", pass), rd_vec_idx, 0);
      chk($sformatf("wait%0d beat0 data", pass), rd_data, exp_mem[32]);
      k = 0;
      while (!rd_done && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk($sformatf("wait%0d done seen", pass), rd_done, 1);
      chk($sformatf("wait%0d last data", pass), rd_data, exp_mem[47]);
      @(negedge clk); @(negedge clk);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
